mac_stream_engine: RTL and testbench

- Parametrised, multi-lane successor of the single-lane MAC accelerator: N_LANES independent signed MAC lanes over packed AXI-stream-style inputs a/b/c and output d.
- Two modes: accumulate mode (bias c + dot product of len beats, one result per job) and simple-multiply mode (one product per beat).
- Job control uses an ap_ctrl_hs-style handshake, so the block drops into the same HWPE wrapper/streamer slot as the existing MAC.

---
 rtl/mac_stream_engine.sv | 213 +++++++++++++++++++++
 tb/tb_mac_stream_engine.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_stream_engine.sv
// mac_stream_engine
//   N_LANES independent signed MAC lanes fed by packed stream beats.
//   Accumulate mode: d = narrow((c + sum(a*b)) >>> shift), one beat per job.
//   Simple-multiply mode: d = narrow((a*b) >>> shift), one beat per a/b beat.
//   Job control is an ap_ctrl_hs-style start/idle/ready/done handshake.
//
// Ports
//   ap_clk, ap_rst            clock, synchronous active-high reset
//   ap_start/ap_idle          job request, accepted only while idle
//   ap_ready                  pulse with the job's last input handshake
//   ap_done                   pulse the cycle after the last d handshake
//   a_i_*, b_i_*              joined operand streams (consumed together)
//   c_i_*                     per-lane bias (accumulate mode only)
//   d_o_*                     result stream, lane k at [k*OUT_WIDTH +: OUT_WIDTH]
//   d_o_sat                   per-lane saturation flags (MAC_STREAM_SAT_EN only)
//   len_i, shift_i, simple_mul_i  job configuration, latched at start
//
// Build option
//   MAC_STREAM_SAT_EN: narrow() saturates instead of truncating and the
//   d_o_sat port is added.
//
// state      | meaning
// S_IDLE     | waiting for ap_start
// S_C_LOAD   | waiting for the bias beat on c
// S_ACCUM    | consuming a/b beats into the accumulators
// S_EMIT     | loading the d register from the accumulators
// S_WAIT_OUT | holding d until the sink takes it
// S_MUL      | one product per a/b beat straight into d
// S_DONE     | ap_done pulse, back to idle
module mac_stream_engine #(
  parameter int N_LANES    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int OUT_WIDTH  = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst,
  input  logic                            ap_start,
  output logic                            ap_done,
  output logic                            ap_idle,
  output logic                            ap_ready,
  input  logic [N_LANES*DATA_WIDTH-1:0]   a_i_TDATA,
  input  logic                            a_i_TVALID,
  output logic                            a_i_TREADY,
  input  logic [N_LANES*DATA_WIDTH-1:0]   b_i_TDATA,
  input  logic                            b_i_TVALID,
  output logic                            b_i_TREADY,
  input  logic [N_LANES*DATA_WIDTH-1:0]   c_i_TDATA,
  input  logic                            c_i_TVALID,
  output logic                            c_i_TREADY,
  output logic [N_LANES*OUT_WIDTH-1:0]    d_o_TDATA,
  output logic                            d_o_TVALID,
`ifdef MAC_STREAM_SAT_EN
  output logic [N_LANES-1:0]              d_o_sat,
`endif
  input  logic                            d_o_TREADY,
  input  logic [LEN_WIDTH-1:0]            len_i,
  input  logic [$clog2(ACC_WIDTH)-1:0]    shift_i,
  input  logic                            simple_mul_i
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_C_LOAD   = 3'd1;
  localparam logic [2:0] S_ACCUM    = 3'd2;
  localparam logic [2:0] S_EMIT     = 3'd3;
  localparam logic [2:0] S_WAIT_OUT = 3'd4;
  localparam logic [2:0] S_MUL      = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  logic [2:0]                       state;
  logic [LEN_WIDTH-1:0]             len_q;
  logic [LEN_WIDTH-1:0]             cnt_q;
  logic [$clog2(ACC_WIDTH)-1:0]     shift_q;
  logic                             simple_q;
  logic signed [ACC_WIDTH-1:0]      acc_q [N_LANES];
  logic [N_LANES*OUT_WIDTH-1:0]     d_q;
  logic                             d_valid_q;
`ifdef MAC_STREAM_SAT_EN
  logic [N_LANES-1:0]               sat_q;
`endif

  logic                             out_free;
  logic                             ab_hs;
  logic                             c_hs;
  logic                             last_beat;
  logic signed [2*DATA_WIDTH-1:0]   prod [N_LANES];
  logic signed [ACC_WIDTH-1:0]      prod_ext [N_LANES];

`ifdef MAC_STREAM_SAT_EN
  // Value fits when every bit from the OUT_WIDTH sign position up matches the MSB.
  function automatic logic is_sat(input logic signed [ACC_WIDTH-1:0] v);
    return v[ACC_WIDTH-1:OUT_WIDTH-1] != {(ACC_WIDTH-OUT_WIDTH+1){v[ACC_WIDTH-1]}};
  endfunction

  function automatic logic [OUT_WIDTH-1:0] narrow(input logic signed [ACC_WIDTH-1:0] v);
    if (is_sat(v)) begin
      return v[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
    return v[OUT_WIDTH-1:0];
  endfunction
`else
  function automatic logic [OUT_WIDTH-1:0] narrow(input logic signed [ACC_WIDTH-1:0] v);
    return OUT_WIDTH'(v);
  endfunction
`endif

  always_comb begin
    for (int k = 0; k < N_LANES; k++) begin
      prod[k]     = $signed(a_i_TDATA[k*DATA_WIDTH +: DATA_WIDTH])
                  * $signed(b_i_TDATA[k*DATA_WIDTH +: DATA_WIDTH]);
      prod_ext[k] = ACC_WIDTH'(prod[k]);
    end
  end

  // a and b are joined: neither is taken unless both are valid, and in MUL
  // the d register must be able to take the new product on the same edge.
  assign out_free  = !d_valid_q || d_o_TREADY;
  assign ab_hs     = a_i_TVALID && b_i_TVALID && out_free
                     && ((state == S_ACCUM) || (state == S_MUL));
  assign c_hs      = c_i_TVALID && (state == S_C_LOAD);
  assign last_beat = (cnt_q == len_q - LEN_WIDTH'(1));

  assign a_i_TREADY = ab_hs;
  assign b_i_TREADY = ab_hs;
  assign c_i_TREADY = (state == S_C_LOAD);
  assign ap_idle    = (state == S_IDLE);
  assign ap_done    = (state == S_DONE);
  assign ap_ready   = (ab_hs && last_beat) || (c_hs && (len_q == '0));
  assign d_o_TDATA  = d_q;
  assign d_o_TVALID = d_valid_q;
`ifdef MAC_STREAM_SAT_EN
  assign d_o_sat    = sat_q;
`endif

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state     <= S_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      shift_q   <= '0;
      simple_q  <= 1'b0;
      d_q       <= '0;
      d_valid_q <= 1'b0;
      for (int k = 0; k < N_LANES; k++) acc_q[k] <= '0;
`ifdef MAC_STREAM_SAT_EN
      sat_q     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            len_q    <= len_i;
            shift_q  <= shift_i;
            simple_q <= simple_mul_i;
            cnt_q    <= '0;
            if (!simple_mul_i)       state <= S_C_LOAD;
            else if (len_i == '0)    state <= S_DONE;
            else                     state <= S_MUL;
          end
        end
        S_C_LOAD: begin
          if (c_hs) begin
            for (int k = 0; k < N_LANES; k++)
              acc_q[k] <= ACC_WIDTH'($signed(c_i_TDATA[k*DATA_WIDTH +: DATA_WIDTH]));
            state <= (len_q == '0) ? S_EMIT : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (ab_hs) begin
            for (int k = 0; k < N_LANES; k++) acc_q[k] <= acc_q[k] + prod_ext[k];
            cnt_q <= cnt_q + LEN_WIDTH'(1);
            if (last_beat) state <= S_EMIT;
          end
        end
        S_EMIT: begin
          for (int k = 0; k < N_LANES; k++) begin
            d_q[k*OUT_WIDTH +: OUT_WIDTH] <= narrow(acc_q[k] >>> shift_q);
`ifdef MAC_STREAM_SAT_EN
            sat_q[k] <= is_sat(acc_q[k] >>> shift_q);
`endif
          end
          d_valid_q <= 1'b1;
          state     <= S_WAIT_OUT;
        end
        S_WAIT_OUT: begin
          if (d_o_TREADY) begin
            d_valid_q <= 1'b0;
            state     <= S_DONE;
          end
        end
        S_MUL: begin
          if (ab_hs) begin
            for (int k = 0; k < N_LANES; k++) begin
              d_q[k*OUT_WIDTH +: OUT_WIDTH] <= narrow(prod_ext[k] >>> shift_q);
`ifdef MAC_STREAM_SAT_EN
              sat_q[k] <= is_sat(prod_ext[k] >>> shift_q);
`endif
            end
            d_valid_q <= 1'b1;
            cnt_q     <= cnt_q + LEN_WIDTH'(1);
            if (last_beat) state <= S_WAIT_OUT;
          end else if (d_o_TREADY) begin
            d_valid_q <= 1'b0;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_stream_engine.sv
module tb_mac_stream_engine;
  localparam int NL = 4;
  localparam int DW = 16;
  localparam int AW = 40;
  localparam int OW = 16;
  localparam int LW = 16;
  localparam int SW = $clog2(AW);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic ap_start = 1'b0;
  logic ap_done, ap_idle, ap_ready;
  logic [NL*DW-1:0] a_data = '0, b_data = '0, c_data = '0;
  logic a_valid = 1'b0, b_valid = 1'b0, c_valid = 1'b0;
  logic a_ready, b_ready, c_ready;
  logic [NL*OW-1:0] d_data;
  logic d_valid;
  logic d_ready = 1'b0;
  logic [LW-1:0] len = '0;
  logic [SW-1:0] shift = '0;
  logic simple = 1'b0;
`ifdef MAC_STREAM_SAT_EN
  logic [NL-1:0] d_sat;
`endif

  int checks = 0;
  int errors = 0;

  logic [NL*DW-1:0] a_src[$];
  logic [NL*DW-1:0] b_src[$];
  logic [NL*OW-1:0] exp_d[$];
  logic [NL-1:0]    exp_s[$];

  mac_stream_engine #(
    .N_LANES(NL), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .LEN_WIDTH(LW)
  ) dut (
    .ap_clk(clk), .ap_rst(rst), .ap_start(ap_start), .ap_done(ap_done),
    .ap_idle(ap_idle), .ap_ready(ap_ready),
    .a_i_TDATA(a_data), .a_i_TVALID(a_valid), .a_i_TREADY(a_ready),
    .b_i_TDATA(b_data), .b_i_TVALID(b_valid), .b_i_TREADY(b_ready),
    .c_i_TDATA(c_data), .c_i_TVALID(c_valid), .c_i_TREADY(c_ready),
    .d_o_TDATA(d_data), .d_o_TVALID(d_valid),
`ifdef MAC_STREAM_SAT_EN
    .d_o_sat(d_sat),
`endif
    .d_o_TREADY(d_ready),
    .len_i(len), .shift_i(shift), .simple_mul_i(simple)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NL*DW-1:0] rep(input int v);
    return {NL{DW'(v)}};
  endfunction

  function automatic longint lane_of(input logic [NL*DW-1:0] w, input int k);
    logic signed [DW-1:0] v;
    v = w[k*DW +: DW];
    return longint'(v);
  endfunction

  function automatic longint wrap_acc(input longint v);
    return (v <<< (64-AW)) >>> (64-AW);
  endfunction

  function automatic longint narrow_ref(input longint v, output logic sat);
`ifdef MAC_STREAM_SAT_EN
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (OW-1)) - 1;
    lo = -(longint'(1) <<< (OW-1));
    sat = (v > hi) || (v < lo);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    sat = 1'b0;
    return (v <<< (64-OW)) >>> (64-OW);
`endif
  endfunction

  // Expected d beats from the job description: dot product plus bias, or
  // per-beat products, each shifted and narrowed.
  task automatic build_expect(input int n, input bit smode, input int sh,
                              input logic [NL*DW-1:0] c_w);
    logic [NL*OW-1:0] w;
    logic [NL-1:0] s;
    longint acc, r;
    logic sf;
    exp_d.delete();
    exp_s.delete();
    if (smode) begin
      for (int j = 0; j < n; j++) begin
        for (int k = 0; k < NL; k++) begin
          r = narrow_ref((lane_of(a_src[j], k) * lane_of(b_src[j], k)) >>> sh, sf);
          w[k*OW +: OW] = r[OW-1:0];
          s[k] = sf;
        end
        exp_d.push_back(w);
        exp_s.push_back(s);
      end
    end else begin
      for (int k = 0; k < NL; k++) begin
        acc = lane_of(c_w, k);
        for (int j = 0; j < n; j++) acc += lane_of(a_src[j], k) * lane_of(b_src[j], k);
        r = narrow_ref(wrap_acc(acc) >>> sh, sf);
        w[k*OW +: OW] = r[OW-1:0];
        s[k] = sf;
      end
      exp_d.push_back(w);
      exp_s.push_back(s);
    end
  endtask

  // Runs one job from posedge+1; leaves at posedge+1. abort_at>0 returns
  // right after that many a/b handshakes without finishing the job.
  task automatic run_job(input int n, input bit smode, input int sh,
                         input logic [NL*DW-1:0] c_w, input int a_delay, input int b_delay,
                         input int stall, input bit rnd_ready, input int abort_at);
    int ai, stall_left, last_d_cyc;
    bit c_done, done_seen, prev_hold, ab_hs, c_hs, exp_rdy;
    logic [NL*OW-1:0] prev_d, ed;
    logic [NL-1:0] es;
    build_expect(n, smode, sh, c_w);
    len = LW'(n);
    shift = SW'(sh);
    simple = smode;
    ap_start = 1'b1;
    @(posedge clk); #1;
    ap_start = 1'b0;
    check("start_leaves_idle", longint'(ap_idle), 0);
    ai = 0; c_done = smode; stall_left = stall; done_seen = 0; prev_hold = 0;
    last_d_cyc = -10; prev_d = '0;
    for (int cyc = 0; cyc < 300 && !done_seen; cyc++) begin
      a_valid = (ai < n || n == 0) && cyc >= a_delay;
      b_valid = (ai < n || n == 0) && cyc >= b_delay;
      a_data  = (ai < n) ? a_src[ai] : '0;
      b_data  = (ai < n) ? b_src[ai] : '0;
      c_valid = !c_done;
      c_data  = c_w;
      d_ready = (stall_left > 0) ? 1'b0 : (rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1);
      @(negedge clk);
      ab_hs = a_ready && a_valid && b_valid;
      c_hs  = c_ready && c_valid;
      check("ab_ready_join", longint'(a_ready), longint'(b_ready));
      check("ab_ready_needs_both", longint'(a_ready && !(a_valid && b_valid)), 0);
      check("ab_ready_out_blocked", longint'(a_ready && d_valid && !d_ready), 0);
      if (smode) check("c_ready_in_mul", longint'(c_ready), 0);
      exp_rdy = (ab_hs && ai == n-1) || (c_hs && n == 0);
      check("ap_ready", longint'(ap_ready), longint'(exp_rdy));
      if (prev_hold) begin
        check("d_valid_held", longint'(d_valid), 1);
        check("d_data_held", longint'(d_data), longint'(prev_d));
      end
      if (d_valid && d_ready) begin
        if (exp_d.size() == 0) begin
          check("d_extra_beat", 1, 0);
        end else begin
          ed = exp_d.pop_front();
          es = exp_s.pop_front();
          check("d_data", longint'(d_data), longint'(ed));
`ifdef MAC_STREAM_SAT_EN
          check("d_sat", longint'(d_sat), longint'(es));
`endif
        end
        last_d_cyc = cyc;
      end
      prev_hold = d_valid && !d_ready;
      prev_d = d_data;
      if (d_valid && stall_left > 0) stall_left--;
      if (ap_done) begin
        done_seen = 1;
        check("done_timing", cyc, (smode && n == 0) ? 0 : last_d_cyc + 1);
      end
      @(posedge clk); #1;
      if (ab_hs) ai++;
      if (c_hs) c_done = 1;
      if (abort_at > 0 && ai == abort_at) break;
    end
    if (abort_at > 0) begin
      check("abort_reached", ai, abort_at);
    end else begin
      a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
      check("done_seen", longint'(done_seen), 1);
      check("ab_beats_consumed", ai, n);
      check("c_consumed", longint'(c_done), 1);
      check("d_beats_left", exp_d.size(), 0);
    end
  endtask

  initial begin
    // Reset with inputs pending: nothing may be accepted.
    a_valid = 1'b1; b_valid = 1'b1; c_valid = 1'b1; d_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_idle", longint'(ap_idle), 1);
    check("rst_done", longint'(ap_done), 0);
    check("rst_ready", longint'(ap_ready), 0);
    check("rst_a_ready", longint'(a_ready), 0);
    check("rst_b_ready", longint'(b_ready), 0);
    check("rst_c_ready", longint'(c_ready), 0);
    check("rst_d_valid", longint'(d_valid), 0);
    check("rst_d_data", longint'(d_data), 0);
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;

    // Accumulate: 10 + 1*5 + 2*6 + 3*7 = 48 per lane.
    a_src = '{rep(1), rep(2), rep(3)};
    b_src = '{rep(5), rep(6), rep(7)};
    run_job(3, 0, 0, rep(10), 0, 0, 0, 0, 0);

    // Abort mid-ACCUM after 2 of 4 beats.
    a_src = '{rep(1), rep(2), rep(3), rep(4)};
    b_src = '{rep(1), rep(1), rep(1), rep(1)};
    run_job(4, 0, 0, rep(0), 0, 0, 0, 0, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_idle", longint'(ap_idle), 1);
    check("abort_d_valid", longint'(d_valid), 0);
    check("abort_a_ready", longint'(a_ready), 0);
    rst = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
    @(posedge clk); #1;
    a_src = '{rep(3)};
    b_src = '{rep(4)};
    run_job(1, 0, 0, rep(0), 0, 0, 0, 0, 0);

    // Simple multiply with a 3-cycle stall: (-2*7)>>>1 = -7.
    a_src = '{rep(-2), rep(-2), rep(-2), rep(-2)};
    b_src = '{rep(7), rep(7), rep(7), rep(7)};
    run_job(4, 1, 1, rep(0), 0, 0, 3, 0, 0);

    // Join skew: b arrives 5 cycles after a.
    a_src = '{rep(1), rep(2), rep(3)};
    b_src = '{rep(5), rep(6), rep(7)};
    run_job(3, 0, 0, rep(10), 0, 5, 0, 0, 0);

    // len=0 in both modes.
    a_src.delete(); b_src.delete();
    run_job(0, 0, 0, rep(-5), 0, 0, 0, 0, 0);
    run_job(0, 1, 0, rep(0), 0, 0, 0, 0, 0);

    // Overflow of the 16-bit result.
    a_src = '{rep(32767), rep(32767)};
    b_src = '{rep(32767), rep(32767)};
    run_job(2, 0, 0, rep(0), 0, 0, 0, 0, 0);

    // Randomized jobs with random back-pressure and skew.
    for (int j = 0; j < 10; j++) begin
      int n;
      bit sm;
      n  = $urandom_range(1, 6);
      sm = 1'($urandom_range(0, 1));
      a_src.delete(); b_src.delete();
      for (int i = 0; i < n; i++) begin
        a_src.push_back({$urandom, $urandom});
        b_src.push_back({$urandom, $urandom});
      end
      run_job(n, sm, $urandom_range(0, 20), {$urandom, $urandom},
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
